mem_arbiter: RTL and testbench

Two-port arbiter that shares the single memory port (`mem_rw_flag`/`mem_addr`/`mem_done` protocol) between the instruction cache (port 0) and the data cache (port 1). Each port gets a one-entry request slot, which captures that cache's one-cycle request pulse. The arbiter grants slots round-robin, issues one transaction at a time to memory and routes `mem_done` back to the owning port. A watchdog terminates transactions that memory never completes.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction cache (port 0)
// and the data cache (port 1). Each port owns a one-entry request slot. Slots
// are granted round-robin, one transaction is outstanding at a time, and a
// watchdog force-completes transactions that memory never finishes.
module mem_arbiter #(
  parameter int TIMEOUT = 1023,  // max cycles spent in WAIT, must be >= 1
  parameter int CNT_W   = 10     // watchdog width, 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  p0_rw_flag,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_write_data,
  input  logic [3:0]  p0_write_mask,
  output logic [31:0] p0_read_data,
  output logic        p0_done,
  output logic        p0_busy,
  input  logic [1:0]  p1_rw_flag,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_write_data,
  input  logic [3:0]  p1_write_mask,
  output logic [31:0] p1_read_data,
  output logic        p1_done,
  output logic        p1_busy,
  output logic [1:0]  mem_rw_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [31:0] mem_read_data,
  output logic        proto_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } slot_t;

  // Watchdog value seen in the TIMEOUT-th WAIT cycle (count starts at 0).
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  slot_t             slot_q [2];
  logic [1:0]        req_rw    [2];
  logic [31:0]       req_addr  [2];
  logic [31:0]       req_wdata [2];
  logic [3:0]        req_wmask [2];
  logic              last_grant_q;
  logic              owner_q;
  logic [CNT_W-1:0]  wd_q;
  logic              issue;
  logic              winner;
  logic              finish;
  logic              timeout_hit;

  assign req_rw[0]    = p0_rw_flag;
  assign req_rw[1]    = p1_rw_flag;
  assign req_addr[0]  = p0_addr;
  assign req_addr[1]  = p1_addr;
  assign req_wdata[0] = p0_write_data;
  assign req_wdata[1] = p1_write_data;
  assign req_wmask[0] = p0_write_mask;
  assign req_wmask[1] = p1_write_mask;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: issue moves to WAIT, completion or watchdog returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (issue) state_d = WAIT;
      WAIT: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: grant selection in IDLE, completion/watchdog in WAIT.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    issue       = 1'b0;
    winner      = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        issue  = !mem_busy && (slot_q[0].valid || slot_q[1].valid);
        // On a tie the port that did not win last time goes next.
        winner = (slot_q[0].valid && slot_q[1].valid) ? ~last_grant_q
                                                      : slot_q[1].valid;
      end
      WAIT: begin
        // A real completion in the last allowed cycle beats the watchdog.
        timeout_hit = !mem_done && (wd_q == WD_LAST);
        finish      = mem_done || timeout_hit;
      end
      default: ;
    endcase
  end

  assign p0_busy      = slot_q[0].valid;
  assign p1_busy      = slot_q[1].valid;
  assign p0_done      = finish && !owner_q;
  assign p1_done      = finish &&  owner_q;
  assign p0_read_data = timeout_hit ? 32'h0 : mem_read_data;
  assign p1_read_data = timeout_hit ? 32'h0 : mem_read_data;

  // Datapath: slot capture/clear, memory request registers, watchdog, errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: slot payloads are reset with their valid bits so nothing
      // undefined can ever reach the registered mem_* outputs.
      for (int n = 0; n < 2; n++) slot_q[n] <= '0;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      wd_q           <= '0;
      mem_rw_flag    <= 2'b00;
      mem_addr       <= 32'h0;
      mem_write_data <= 32'h0;
      mem_write_mask <= 4'h0;
      proto_err      <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      mem_rw_flag <= 2'b00;
      if (issue) begin
        mem_rw_flag    <= slot_q[winner].rw;
        mem_addr       <= slot_q[winner].addr;
        mem_write_data <= slot_q[winner].wdata;
        mem_write_mask <= slot_q[winner].wmask;
        owner_q        <= winner;
        last_grant_q   <= winner;
        wd_q           <= '0;
      end else if (state_q == WAIT) begin
        wd_q <= wd_q + CNT_W'(1);
      end

      if (timeout_hit) timeout_err <= 1'b1;

      for (int n = 0; n < 2; n++) begin
        if (issue && winner == 1'(n)) slot_q[n].valid <= 1'b0;
        if (req_rw[n] == 2'd3) begin
          proto_err <= 1'b1;
        end else if (req_rw[n] != 2'd0) begin
          // Capture is placed after the clear so it wins on the issue edge.
          if (!slot_q[n].valid || (issue && winner == 1'(n))) begin
            slot_q[n].valid <= 1'b1;
            slot_q[n].rw    <= req_rw[n];
            slot_q[n].addr  <= req_addr[n];
            slot_q[n].wdata <= req_wdata[n];
            slot_q[n].wmask <= req_wmask[n];
          end else begin
            proto_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against mem_arbiter with a transaction-level
// reference model compared every cycle, plus literal expectations per scenario.
module tb_mem_arbiter;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  p_rw    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wmask [2];
  logic [31:0] p_rdata [2];
  logic        p_done  [2];
  logic        p_busy  [2];
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_mask;
  logic        mem_busy, mem_done;
  logic        proto_err, timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .p0_rw_flag(p_rw[0]), .p0_addr(p_addr[0]), .p0_write_data(p_wdata[0]),
    .p0_write_mask(p_wmask[0]), .p0_read_data(p_rdata[0]), .p0_done(p_done[0]),
    .p0_busy(p_busy[0]),
    .p1_rw_flag(p_rw[1]), .p1_addr(p_addr[1]), .p1_write_data(p_wdata[1]),
    .p1_write_mask(p_wmask[1]), .p1_read_data(p_rdata[1]), .p1_done(p_done[1]),
    .p1_busy(p_busy[1]),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_read_data(mem_read_data), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  req_t        m_slot [2];
  bit          m_out;        // a transaction is outstanding
  int          m_owner;
  int          m_last;
  int          m_issue_cyc;  // cycle whose closing edge issued the transaction
  logic [1:0]  m_flag;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  bit          m_perr, m_terr;

  task automatic model_reset();
    for (int n = 0; n < 2; n++) m_slot[n] = '{valid: 1'b0, rw: 2'd0, addr: 32'h0, wdata: 32'h0, wmask: 4'h0};
    m_out = 0; m_owner = 0; m_last = 1; m_issue_cyc = -100;
    m_flag = 2'd0; m_addr = 32'h0; m_wdata = 32'h0; m_wmask = 4'h0;
    m_perr = 0; m_terr = 0;
  endtask

  // Advance the model across the edge that ends cycle cyc.
  task automatic model_step();
    bit was_out;
    int w;
    if (!rst) begin
      model_reset();
      return;
    end
    was_out = m_out;
    if (m_out) begin
      if (mem_done) m_out = 0;
      else if (cyc - m_issue_cyc == TIMEOUT) begin m_out = 0; m_terr = 1; end
    end
    if (!was_out && !mem_busy && (m_slot[0].valid || m_slot[1].valid)) begin
      if (m_slot[0].valid && m_slot[1].valid) w = 1 - m_last;
      else w = m_slot[0].valid ? 0 : 1;
      m_flag = m_slot[w].rw; m_addr = m_slot[w].addr;
      m_wdata = m_slot[w].wdata; m_wmask = m_slot[w].wmask;
      m_slot[w].valid = 0;
      m_out = 1; m_owner = w; m_last = w; m_issue_cyc = cyc;
    end
    for (int n = 0; n < 2; n++) begin
      if (p_rw[n] == 2'd3) m_perr = 1;
      else if (p_rw[n] != 2'd0) begin
        if (m_slot[n].valid) m_perr = 1;
        else m_slot[n] = '{valid: 1'b1, rw: p_rw[n], addr: p_addr[n], wdata: p_wdata[n], wmask: p_wmask[n]};
      end
    end
  endtask

  task automatic compare_outputs();
    logic [1:0]  e_flag;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_wmask;
    bit          e_done [2];
    bit          e_busy [2];
    bit          e_perr, e_terr, to;
    int          waited;
    if (!rst) begin
      e_flag = 2'd0; e_addr = 32'h0; e_wdata = 32'h0; e_wmask = 4'h0;
      e_perr = 0; e_terr = 0; e_rd = mem_read_data;
      for (int n = 0; n < 2; n++) begin e_done[n] = 0; e_busy[n] = 0; end
    end else begin
      waited  = cyc - m_issue_cyc;
      to      = m_out && !mem_done && waited == TIMEOUT;
      e_flag  = (cyc == m_issue_cyc + 1) ? m_flag : 2'd0;
      e_addr  = m_addr; e_wdata = m_wdata; e_wmask = m_wmask;
      e_perr  = m_perr; e_terr = m_terr;
      e_rd    = to ? 32'h0 : mem_read_data;
      for (int n = 0; n < 2; n++) begin
        e_done[n] = m_out && m_owner == n && (mem_done || waited == TIMEOUT);
        e_busy[n] = m_slot[n].valid;
      end
    end
    check("cmp_mem_rw_flag", 32'(mem_rw_flag), 32'(e_flag));
    check("cmp_mem_addr", mem_addr, e_addr);
    check("cmp_mem_write_data", mem_write_data, e_wdata);
    check("cmp_mem_write_mask", 32'(mem_write_mask), 32'(e_wmask));
    check("cmp_proto_err", 32'(proto_err), 32'(e_perr));
    check("cmp_timeout_err", 32'(timeout_err), 32'(e_terr));
    for (int n = 0; n < 2; n++) begin
      check($sformatf("cmp_p%0d_done", n), 32'(p_done[n]), 32'(e_done[n]));
      check($sformatf("cmp_p%0d_busy", n), 32'(p_busy[n]), 32'(e_busy[n]));
      check($sformatf("cmp_p%0d_read_data", n), p_rdata[n], e_rd);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    compare_outputs();
  end

  // ---------------- issue / completion log ----------------
  typedef struct { int c; logic [1:0] rw; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask; } iss_t;
  typedef struct { int c; int port; } dn_t;
  iss_t iss_q [$];
  dn_t  dn_q  [$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (mem_rw_flag != 2'd0)
        iss_q.push_back('{c: cyc, rw: mem_rw_flag, addr: mem_addr, wdata: mem_write_data, wmask: mem_write_mask});
      for (int n = 0; n < 2; n++) if (p_done[n]) dn_q.push_back('{c: cyc, port: n});
    end
  end

  // ---------------- memory responder (when enabled) ----------------
  bit mem_on  = 0;
  int mem_lat = 1;
  int pend    = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (mem_on) begin
      mem_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_done      = 1'b1;
          mem_read_data = mem_addr ^ 32'h5A5A_0000;
        end
      end
      if (mem_rw_flag != 2'd0) pend = mem_lat;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_ports();
    for (int n = 0; n < 2; n++) begin
      p_rw[n] = 2'd0; p_addr[n] = 32'h0; p_wdata[n] = 32'h0; p_wmask[n] = 4'h0;
    end
  endtask

  task automatic set_req(input int n, input logic [1:0] rw, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    p_rw[n] = rw; p_addr[n] = a; p_wdata[n] = d; p_wmask[n] = m;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_on = 0; pend = 0;
    idle_ports();
    mem_busy = 1'b0; mem_done = 1'b0; mem_read_data = 32'h0;
    tick(); tick();
    rst = 1'b1;
    tick();
    iss_q.delete();
    dn_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rw_flag"}, 32'(mem_rw_flag), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    check({tag, "_mem_write_mask"}, 32'(mem_write_mask), 32'd0);
    check({tag, "_p0_done"}, 32'(p_done[0]), 32'd0);
    check({tag, "_p1_done"}, 32'(p_done[1]), 32'd0);
    check({tag, "_p0_busy"}, 32'(p_busy[0]), 32'd0);
    check({tag, "_p1_busy"}, 32'(p_busy[1]), 32'd0);
    check({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t0;
    int n0, n1;
    rst = 1'b0;
    idle_ports();
    mem_busy = 1'b0; mem_done = 1'b0; mem_read_data = 32'h0;
    tick();
    #1;
    check_all_zero("reset");

    // Single read: issue two cycles after the pulse, done three cycles after issue.
    // The done lands in the last cycle the watchdog allows, so real data must win.
    do_reset();
    t0 = cyc;
    set_req(0, 2'd1, 32'h100, 32'h0, 4'h0);
    tick(); idle_ports();
    check("single_slot_busy", 32'(p_busy[0]), 32'd1);
    tick();
    check("single_issue_flag", 32'(mem_rw_flag), 32'd1);
    check("single_issue_addr", mem_addr, 32'h100);
    check("single_issue_cycle", 32'(cyc - t0), 32'd2);
    tick();
    check("single_flag_pulse", 32'(mem_rw_flag), 32'd0);
    check("single_addr_held", mem_addr, 32'h100);
    tick(); tick();
    mem_done = 1'b1; mem_read_data = 32'hDEADBEEF;
    #1;
    check("single_p0_done", 32'(p_done[0]), 32'd1);
    check("single_p0_data", p_rdata[0], 32'hDEADBEEF);
    check("single_p1_quiet", 32'(p_done[1]), 32'd0);
    tick();
    mem_done = 1'b0;
    #1;
    check("single_done_pulse", 32'(p_done[0]), 32'd0);
    check("single_no_timeout", 32'(timeout_err), 32'd0);

    // Contention: p0 read and p1 write in the same cycle; p0 wins the first tie.
    do_reset();
    mem_on = 1; mem_lat = 2;
    t0 = cyc;
    set_req(0, 2'd1, 32'h10, 32'h0, 4'h0);
    set_req(1, 2'd2, 32'h20, 32'hCAFEF00D, 4'b0011);
    tick(); idle_ports();
    repeat (10) tick();
    set_req(0, 2'd1, 32'h30, 32'h0, 4'h0);
    set_req(1, 2'd1, 32'h40, 32'h0, 4'h0);
    tick(); idle_ports();
    repeat (10) tick();
    check("cont_issue_count", 32'(iss_q.size()), 32'd4);
    if (iss_q.size() >= 4 && dn_q.size() >= 1) begin
      check("cont_first_addr", iss_q[0].addr, 32'h10);
      check("cont_first_cycle", 32'(iss_q[0].c - t0), 32'd2);
      check("cont_first_done_port", 32'(dn_q[0].port), 32'd0);
      check("cont_first_done_cycle", 32'(dn_q[0].c - t0), 32'd4);
      check("cont_second_gap", 32'(iss_q[1].c - dn_q[0].c), 32'd2);
      check("cont_second_rw", 32'(iss_q[1].rw), 32'd2);
      check("cont_second_addr", iss_q[1].addr, 32'h20);
      check("cont_second_wdata", iss_q[1].wdata, 32'hCAFEF00D);
      check("cont_second_wmask", 32'(iss_q[1].wmask), 32'b0011);
      check("cont_next_tie_addr", iss_q[2].addr, 32'h30);
      check("cont_next_tie_second", iss_q[3].addr, 32'h40);
    end

    // Streaming: p1 re-requests in each of its done cycles, p0 keeps a slot pending.
    do_reset();
    mem_on = 1; mem_lat = 1;
    set_req(1, 2'd1, 32'h1000, 32'h0, 4'h0);
    tick(); idle_ports();
    set_req(0, 2'd1, 32'h2000, 32'h0, 4'h0);
    n0 = 1; n1 = 1;
    for (int k = 0; k < 100 && dn_q.size() < 16; k++) begin
      tick();
      idle_ports();
      if (p_done[1] && n1 < 8) begin set_req(1, 2'd1, 32'h1000 + 32'(n1), 32'h0, 4'h0); n1++; end
      if (p_done[0] && n0 < 8) begin set_req(0, 2'd1, 32'h2000 + 32'(n0), 32'h0, 4'h0); n0++; end
    end
    idle_ports();
    tick();
    check("stream_done_count", 32'(dn_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < iss_q.size(); i++)
      check($sformatf("stream_grant_%0d", i), iss_q[i].addr,
            (i % 2 == 0) ? 32'h1000 + 32'(i / 2) : 32'h2000 + 32'(i / 2));
    check("stream_no_proto_err", 32'(proto_err), 32'd0);
    check("stream_no_timeout", 32'(timeout_err), 32'd0);

    // Backpressure: mem_busy high for five cycles with p0 pending.
    do_reset();
    mem_on = 1; mem_lat = 1;
    mem_busy = 1'b1;
    set_req(0, 2'd1, 32'h400, 32'h0, 4'h0);
    for (int k = 1; k <= 4; k++) begin
      tick(); idle_ports();
      check($sformatf("bp_hold_flag_%0d", k), 32'(mem_rw_flag), 32'd0);
      check($sformatf("bp_hold_busy_%0d", k), 32'(p_busy[0]), 32'd1);
    end
    tick();
    mem_busy = 1'b0;
    check("bp_release_flag", 32'(mem_rw_flag), 32'd0);
    check("bp_release_busy", 32'(p_busy[0]), 32'd1);
    tick();
    check("bp_issue_flag", 32'(mem_rw_flag), 32'd1);
    check("bp_issue_addr", mem_addr, 32'h400);
    check("bp_slot_free", 32'(p_busy[0]), 32'd0);
    repeat (3) tick();

    // Protocol error: second back-to-back request while the slot is full.
    do_reset();
    mem_on = 1; mem_lat = 1;
    mem_busy = 1'b1;
    set_req(1, 2'd1, 32'h500, 32'h0, 4'h0);
    tick();
    set_req(1, 2'd1, 32'h504, 32'h0, 4'h0);
    check("perr_before", 32'(proto_err), 32'd0);
    tick(); idle_ports();
    check("perr_set", 32'(proto_err), 32'd1);
    check("perr_slot_busy", 32'(p_busy[1]), 32'd1);
    tick();
    mem_busy = 1'b0;
    tick();
    check("perr_issue_flag", 32'(mem_rw_flag), 32'd1);
    check("perr_issue_addr", mem_addr, 32'h500);
    repeat (3) tick();

    // Watchdog: memory never answers; forced done on the 4th WAIT cycle.
    do_reset();
    mem_read_data = 32'h1234_5678;
    set_req(0, 2'd1, 32'h600, 32'h0, 4'h0);
    tick(); idle_ports();
    tick();
    check("wd_issue_flag", 32'(mem_rw_flag), 32'd1);
    tick(); tick();
    check("wd_not_yet", 32'(p_done[0]), 32'd0);
    tick();
    check("wd_forced_done", 32'(p_done[0]), 32'd1);
    check("wd_forced_data", p_rdata[0], 32'h0);
    check("wd_err_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("wd_done_pulse", 32'(p_done[0]), 32'd0);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    tick();
    mem_done = 1'b1;
    #1;
    check("wd_late_done_p0", 32'(p_done[0]), 32'd0);
    check("wd_late_done_p1", 32'(p_done[1]), 32'd0);
    tick();
    mem_done = 1'b0;
    set_req(0, 2'd1, 32'h700, 32'h0, 4'h0);
    tick(); idle_ports();
    tick();
    check("wd_next_flag", 32'(mem_rw_flag), 32'd1);
    check("wd_next_addr", mem_addr, 32'h700);
    tick();
    mem_done = 1'b1; mem_read_data = 32'hABCD_0123;
    #1;
    check("wd_next_done", 32'(p_done[0]), 32'd1);
    check("wd_next_data", p_rdata[0], 32'hABCD_0123);
    tick();
    mem_done = 1'b0; mem_read_data = 32'h0;

    // Reset in the middle of WAIT aborts the transaction at once.
    set_req(1, 2'd2, 32'h800, 32'h1111_2222, 4'hF);
    tick(); idle_ports();
    tick();
    check("rst_issue_flag", 32'(mem_rw_flag), 32'd2);
    tick();
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst = 1'b1;
    tick();
    mem_done = 1'b1;
    #1;
    check("midrst_late_p0", 32'(p_done[0]), 32'd0);
    check("midrst_late_p1", 32'(p_done[1]), 32'd0);
    tick();
    mem_done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
